tema3_2b_scan_ctrl: RTL

Controller that sequences the 3-switch / 4-LED combinational datapath (tema3_2b). It drives sw_out[2:0] into the datapath and captures led_in[3:0] back into a 32-bit truth-table register. Two modes:
- Auto: steps all 8 combinations 0..7 with a fixed dwell per combination.
- Manual: applies board switches and captures one entry per debounced button press.
It sits between board I/O and the datapath and gives a hardware self-test of the combinational block.

---
 rtl/tema3_2b_scan_ctrl_pkg.sv | 33 +++
 rtl/tema3_2b_scan_ctrl_if.sv | 29 ++
 rtl/tema3_2b_scan_ctrl_btn_debounce.sv | 44 ++++
 rtl/tema3_2b_scan_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tema3_2b_scan_ctrl_pkg.sv
// Shared types and constants for the tema3_2b scan controller slice.
// Holds the FSM state type, the datapath dimensions and a helper that
// writes one 4-bit entry into the packed 32-bit truth table.
package tema3_scan_pkg;

    localparam int NUM_COMB = 8;
    localparam int SW_W     = 3;
    localparam int LED_W    = 4;
    localparam int RES_W    = 32;

    localparam logic [SW_W-1:0] LAST_IDX = SW_W'(NUM_COMB - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DWELL,
        DONE
    } scan_state_t;

    // Returns the table with entry idx replaced by val, other entries untouched.
    function automatic logic [RES_W-1:0] setEntry(
        input logic [RES_W-1:0] tab,
        input logic [SW_W-1:0]  idx,
        input logic [LED_W-1:0] val
    );
        logic [RES_W-1:0] res;
        res = tab;
        res[idx * LED_W +: LED_W] = val;
        return res;
    endfunction

endpackage

// File: rtl/tema3_2b_scan_ctrl_if.sv
// Board/datapath side bundle of the tema3_2b scan controller.
// master: whoever drives the switches, button and LED feedback.
// slave : the controller itself.
interface tema3_2b_scan_ctrl_if;
    import tema3_scan_pkg::*;

    logic                start;
    logic                mode_auto;
    logic [SW_W-1:0]     man_sw;
    logic                step_btn;
    logic [LED_W-1:0]    led_in;
    logic [SW_W-1:0]     sw_out;
    logic [RES_W-1:0]    result;
    logic [SW_W-1:0]     cur_idx;
    logic                busy;
    logic                done;
    logic                mismatch;

    modport master (
        output start, mode_auto, man_sw, step_btn, led_in,
        input  sw_out, result, cur_idx, busy, done, mismatch
    );

    modport slave (
        input  start, mode_auto, man_sw, step_btn, led_in,
        output sw_out, result, cur_idx, busy, done, mismatch
    );

endinterface

// File: rtl/tema3_2b_scan_ctrl_btn_debounce.sv
// Level debouncer for the manual capture button.
// A change of the raw input is accepted once it has been seen for
// DEB_CYCLES consecutive samples; rise pulses for one cycle when the
// accepted level goes high.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // Count consecutive samples that differ from the accepted level; any glitch back restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_rise <= 1'b0;
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= raw;
                r_rise  <= raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/tema3_2b_scan_ctrl.sv
// Scan controller for the tema3_2b 3-switch / 4-LED combinational block.
// Auto mode walks all 8 switch combinations, holding each for STEP_CYCLES
// and sampling the LEDs SETTLE_CYCLES after every switch change. Manual
// mode mirrors the board switches and captures one entry per debounced
// button press.
// Optional build macro: SCAN_CHECK_EN adds a compare of the finished
// table against GOLDEN, reported on mismatch; otherwise mismatch is 0.
module tema3_2b_scan_ctrl
    import tema3_scan_pkg::*;
#(
    parameter int          STEP_CYCLES   = 10,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          DEB_CYCLES    = 4,
    parameter logic [31:0] GOLDEN        = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    tema3_2b_scan_ctrl_if.slave  bus
);
    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam logic [STEP_W-1:0] SETTLE_LAST = STEP_W'(SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);

    scan_state_t         r_state;
    logic [SW_W-1:0]     r_swOut;
    logic [SW_W-1:0]     r_curIdx;
    logic [RES_W-1:0]    r_result;
    logic                r_busy;
    logic                r_done;
    logic [STEP_W-1:0]   r_stepCnt;
    logic                r_manActive;
    logic [STEP_W-1:0]   r_manCnt;
`ifdef SCAN_CHECK_EN
    logic                r_mismatch;
`endif

    logic                w_btnLevel;
    logic                w_btnRise;
    logic                w_manPress;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_stepDeb (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.step_btn),
        .level (w_btnLevel),
        .rise  (w_btnRise)
    );

    // A new manual capture only starts in manual mode and when no settle wait is pending.
    assign w_manPress = w_btnRise && w_btnLevel && !bus.mode_auto && !r_manActive;

    // Scan FSM plus the manual capture path; r_stepCnt counts cycles since the last sw_out change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_swOut     <= '0;
            r_curIdx    <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stepCnt   <= '0;
            r_manActive <= 1'b0;
            r_manCnt    <= '0;
`ifdef SCAN_CHECK_EN
            r_mismatch  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.mode_auto && bus.start) begin
                        r_state     <= SETTLE;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_result    <= '0;
                        r_curIdx    <= '0;
                        r_swOut     <= '0;
                        r_stepCnt   <= '0;
                        r_manActive <= 1'b0;
                        r_manCnt    <= '0;
`ifdef SCAN_CHECK_EN
                        r_mismatch  <= 1'b0;
`endif
                    end else begin
                        if (!bus.mode_auto) begin
                            r_swOut  <= bus.man_sw;
                            r_curIdx <= bus.man_sw;
                        end
                        if (r_manActive) begin
                            if (r_manCnt == SETTLE_LAST) begin
                                r_result    <= setEntry(r_result, r_curIdx, bus.led_in);
                                r_manActive <= 1'b0;
                                r_manCnt    <= '0;
                            end else begin
                                r_manCnt <= r_manCnt + 1'b1;
                            end
                        end else if (w_manPress) begin
                            r_manActive <= 1'b1;
                            r_manCnt    <= '0;
                        end
                    end
                end

                SETTLE: begin
                    r_stepCnt <= r_stepCnt + 1'b1;
                    if (r_stepCnt == SETTLE_LAST) begin
                        r_state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    r_result  <= setEntry(r_result, r_curIdx, bus.led_in);
                    r_stepCnt <= r_stepCnt + 1'b1;
                    r_state   <= DWELL;
                end

                DWELL: begin
                    if (r_stepCnt == STEP_LAST) begin
                        r_stepCnt <= '0;
                        if (r_curIdx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
`ifdef SCAN_CHECK_EN
                            r_mismatch <= (r_result != GOLDEN);
`endif
                        end else begin
                            r_curIdx <= r_curIdx + 1'b1;
                            r_swOut  <= r_swOut + 1'b1;
                            r_state  <= SETTLE;
                        end
                    end else begin
                        r_stepCnt <= r_stepCnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sw_out  = r_swOut;
    assign bus.cur_idx = r_curIdx;
    assign bus.result  = r_result;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
`ifdef SCAN_CHECK_EN
    assign bus.mismatch = r_mismatch;
`else
    // GOLDEN is only meaningful with the checker; folding it into a constant 0 keeps it referenced.
    assign bus.mismatch = 1'b0 & (^GOLDEN);
`endif

endmodule
